decl_check: RTL and testbench



---
 rtl/decl_pkg.sv | 51 +++++
 rtl/decl_kw_match.sv | 27 ++
 rtl/decl_check.sv | 154 +++++++++++++++
 tb/tb_decl_check.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decl_pkg.sv
// Shared constants for the declaration checker: FSM states, character codes,
// keyword literals and type codes, plus character-class helpers.
package decl_pkg;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_KW     = 4'd1;
  localparam logic [3:0] ST_KW_SP  = 4'd2;
  localparam logic [3:0] ST_ID     = 4'd3;
  localparam logic [3:0] ST_ID_SP  = 4'd4;
  localparam logic [3:0] ST_COMMA  = 4'd5;
  localparam logic [3:0] ST_ERR    = 4'd6;
  localparam logic [3:0] ST_ASG    = 4'd7;
  localparam logic [3:0] ST_NUM    = 4'd8;
  localparam logic [3:0] ST_NUM_SP = 4'd9;

  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_COMMA = 8'h2c;
  localparam logic [7:0] CH_SEMI  = 8'h3b;
  localparam logic [7:0] CH_EQ    = 8'h3d;
  localparam logic [7:0] CH_US    = 8'h5f;

  localparam logic [23:0] KW_INT  = "int";
  localparam logic [31:0] KW_CHAR = "char";
  localparam logic [31:0] KW_LONG = "long";

  localparam logic [1:0] TY_INT  = 2'd0;
  localparam logic [1:0] TY_CHAR = 2'd1;
  localparam logic [1:0] TY_LONG = 2'd2;

  function automatic logic is_ws(input logic [7:0] c);
    return (c == CH_SP) || (c == CH_TAB);
  endfunction

  function automatic logic is_alpha(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5a)) || ((c >= 8'h61) && (c <= 8'h7a));
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_id_start(input logic [7:0] c);
    return is_alpha(c) || (c == CH_US);
  endfunction

  function automatic logic is_id_char(input logic [7:0] c);
    return is_id_start(c) || is_digit(c);
  endfunction

endpackage

// File: rtl/decl_kw_match.sv
// Keyword matcher on the 4-character tail buffer; only lengths 3 and 4 can
// match, so longer words sharing a keyword tail are not misread.
module decl_kw_match
  import decl_pkg::*;
(
  input  logic [31:0] i_buf,
  input  logic [4:0]  i_len,
  output logic        o_hit,
  output logic [1:0]  o_type
);

  always_comb begin
    o_hit  = 1'b0;
    o_type = TY_INT;
    if (i_len == 5'd3 && i_buf[23:0] == KW_INT) begin
      o_hit  = 1'b1;
      o_type = TY_INT;
    end else if (i_len == 5'd4 && i_buf == KW_CHAR) begin
      o_hit  = 1'b1;
      o_type = TY_CHAR;
    end else if (i_len == 5'd4 && i_buf == KW_LONG) begin
      o_hit  = 1'b1;
      o_type = TY_LONG;
    end
  end

endmodule

// File: rtl/decl_check.sv
// Streaming C-like declaration checker, one character per accepted beat.
// Define DECL_INIT_EN to allow "ID = digits" initialisers.
module decl_check
  import decl_pkg::*;
#(
  parameter int MAX_ID_LEN = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             out,
  output logic             err,
  output logic [CNT_W-1:0] id_count,
  output logic [1:0]       type_sel
);

  localparam logic [4:0] LEN_SAT = 5'(MAX_ID_LEN + 1);

  logic [3:0]       r_state;
  logic [31:0]      r_buf;
  logic [4:0]       r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_type;

  logic             w_hit;
  logic [1:0]       w_type;
  logic             w_id_ok;
  logic             w_term;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_inc;

  decl_kw_match u_kw (
    .i_buf  (r_buf),
    .i_len  (r_len),
    .o_hit  (w_hit),
    .o_type (w_type)
  );

  assign w_id_ok   = !w_hit && (r_len != LEN_SAT);
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_term   = is_ws(in) || (in == CH_COMMA);
    w_accept = (r_state == ST_ID && w_id_ok) || (r_state == ST_ID_SP);
`ifdef DECL_INIT_EN
    if (in == CH_EQ) w_term = 1'b1;
    if (r_state == ST_NUM || r_state == ST_NUM_SP) w_accept = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_buf    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_type   <= TY_INT;
      out      <= 1'b0;
      err      <= 1'b0;
      id_count <= '0;
      type_sel <= TY_INT;
    end else begin
      out <= 1'b0;
      err <= 1'b0;
      if (in_valid) begin
        if (in == CH_SEMI) begin
          // every ';' closes the statement; only a blank one is silent
          r_state <= ST_IDLE;
          if (r_state != ST_IDLE) begin
            if (w_accept) begin
              out      <= 1'b1;
              id_count <= (r_state == ST_ID) ? w_cnt_inc : r_cnt;
              type_sel <= r_type;
            end else begin
              err <= 1'b1;
            end
          end
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (is_alpha(in)) begin
                r_buf   <= {24'h0, in};
                r_len   <= 5'd1;
                r_state <= ST_KW;
              end else if (!is_ws(in)) begin
                r_state <= ST_ERR;
              end
            end
            ST_KW: begin
              if (is_alpha(in) && r_len != 5'd4) begin
                r_buf <= {r_buf[23:0], in};
                r_len <= r_len + 5'd1;
              end else if (is_ws(in) && w_hit) begin
                r_type  <= w_type;
                r_state <= ST_KW_SP;
              end else begin
                r_state <= ST_ERR;
              end
            end
            ST_KW_SP, ST_COMMA: begin
              if (is_id_start(in)) begin
                r_buf   <= {24'h0, in};
                r_len   <= 5'd1;
                r_state <= ST_ID;
                if (r_state == ST_KW_SP) r_cnt <= '0;
              end else if (!is_ws(in)) begin
                r_state <= ST_ERR;
              end
            end
            ST_ID: begin
              if (is_id_char(in)) begin
                r_buf <= {r_buf[23:0], in};
                if (r_len != LEN_SAT) r_len <= r_len + 5'd1;
              end else if (w_term && w_id_ok) begin
                r_cnt <= w_cnt_inc;
                if (is_ws(in))            r_state <= ST_ID_SP;
                else if (in == CH_COMMA)  r_state <= ST_COMMA;
                else                      r_state <= ST_ASG;
              end else begin
                r_state <= ST_ERR;
              end
            end
            ST_ID_SP: begin
              if (in == CH_COMMA)  r_state <= ST_COMMA;
`ifdef DECL_INIT_EN
              else if (in == CH_EQ) r_state <= ST_ASG;
`endif
              else if (!is_ws(in)) r_state <= ST_ERR;
            end
`ifdef DECL_INIT_EN
            ST_ASG: begin
              if (is_digit(in))    r_state <= ST_NUM;
              else if (!is_ws(in)) r_state <= ST_ERR;
            end
            ST_NUM: begin
              if (is_ws(in))             r_state <= ST_NUM_SP;
              else if (in == CH_COMMA)   r_state <= ST_COMMA;
              else if (!is_digit(in))    r_state <= ST_ERR;
            end
            ST_NUM_SP: begin
              if (in == CH_COMMA)  r_state <= ST_COMMA;
              else if (!is_ws(in)) r_state <= ST_ERR;
            end
`endif
            default: r_state <= ST_ERR;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_decl_check.sv
// Self-checking bench for decl_check: directed table, multi-cycle corner
// sequences, and random statements checked against a string-level parser.
module tb_decl_check;

  localparam int MAX_ID_LEN = 8;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [7:0]       in = 8'h00;
  logic             out;
  logic             err;
  logic [CNT_W-1:0] id_count;
  logic [1:0]       type_sel;

  decl_check #(.MAX_ID_LEN(MAX_ID_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .out(out), .err(err), .id_count(id_count), .type_sel(type_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    string txt;
    bit    e_out;
    bit    e_err;
    int    e_cnt;
    int    e_ty;
  } vec_t;

  vec_t  tbl[$];
  int    checks = 0;
  int    errors = 0;
  string cur = "";
  string last = "";
  int    ecnt = 0;
  int    ety  = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d stmt \"%s\"", nm, got, exp, last);
    end
  endtask

  function automatic bit c_ws(input byte c);
    return c == 8'h20 || c == 8'h09;
  endfunction
  function automatic bit c_dig(input byte c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction
  function automatic bit c_idc(input byte c);
    return (c >= 8'h41 && c <= 8'h5a) || (c >= 8'h61 && c <= 8'h7a) || c == 8'h5f || c_dig(c);
  endfunction
  function automatic bit is_kw(input string w);
    return w == "int" || w == "char" || w == "long";
  endfunction

  // res: 0 = blank statement, 1 = legal, 2 = illegal
  function automatic void ref_eval(input string s, output int res, output int cnt, output int ty);
    int p = 0;
    int n = s.len();
    int st;
    string w;
    cnt = 0; ty = 0; res = 2;
    while (p < n && c_ws(s[p])) p++;
    if (p == n) begin res = 0; return; end
    st = p;
    while (p < n && c_idc(s[p])) p++;
    w = (p > st) ? s.substr(st, p - 1) : "";
    if (w == "int") ty = 0;
    else if (w == "char") ty = 1;
    else if (w == "long") ty = 2;
    else return;
    st = p;
    while (p < n && c_ws(s[p])) p++;
    if (p == st) return;
    forever begin
      st = p;
      while (p < n && c_idc(s[p])) p++;
      if (p == st) return;
      w = s.substr(st, p - 1);
      if (c_dig(w[0]) || w.len() > MAX_ID_LEN || is_kw(w)) return;
      cnt++;
      while (p < n && c_ws(s[p])) p++;
`ifdef DECL_INIT_EN
      if (p < n && s[p] == 8'h3d) begin
        p++;
        while (p < n && c_ws(s[p])) p++;
        st = p;
        while (p < n && c_dig(s[p])) p++;
        if (p == st) return;
        while (p < n && c_ws(s[p])) p++;
      end
`endif
      if (p == n) begin
        res = 1;
        if (cnt > CNT_MAX) cnt = CNT_MAX;
        return;
      end
      if (s[p] != 8'h2c) return;
      p++;
      while (p < n && c_ws(s[p])) p++;
    end
  endfunction

  task automatic beat(input byte c, input bit v);
    int res, cnt, ty;
    bit eo = 1'b0;
    bit ee = 1'b0;
    in = c;
    in_valid = v;
    @(posedge clk); #1;
    if (v) begin
      if (c == 8'h3b) begin
        last = cur;
        ref_eval(cur, res, cnt, ty);
        cur = "";
        if (res == 1) begin eo = 1'b1; ecnt = cnt; ety = ty; end
        else if (res == 2) ee = 1'b1;
      end else begin
        cur = $sformatf("%s%c", cur, c);
      end
    end
    chk("out", out, eo);
    chk("err", err, ee);
    chk("id_count", id_count, ecnt);
    chk("type_sel", type_sel, ety);
    in_valid = 1'b0;
  endtask

  // gap: 0 full rate, 1 idle after every beat, 2 random idles
  task automatic send(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      beat(s[i], 1'b1);
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) beat(8'h00, 1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    cur = ""; last = "(reset)"; ecnt = 0; ety = 0;
    chk("rst_out", out, 0);
    chk("rst_err", err, 0);
    chk("rst_id_count", id_count, 0);
    chk("rst_type_sel", type_sel, 0);
  endtask

  task automatic add(input string t, input bit o, input bit e, input int c, input int ty);
    vec_t v;
    v.txt = t; v.e_out = o; v.e_err = e; v.e_cnt = c; v.e_ty = ty;
    tbl.push_back(v);
  endtask

  function automatic string rand_id();
    string s = "";
    int n, k;
    byte c;
    case ($urandom_range(0, 11))
      0: return "int";
      1: return "char";
      2: return "long";
      default: ;
    endcase
    n = $urandom_range(1, 10);
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 37);
      if (i == 0 && $urandom_range(0, 7) != 0) k = k % 26;
      if (k < 26) c = byte'(97 + k);
      else if (k < 36) c = byte'(48 + k - 26);
      else c = 8'h5f;
      s = $sformatf("%s%c", s, c);
    end
    return s;
  endfunction

  function automatic string gen_stmt();
    string s = "";
    int n;
    if ($urandom_range(0, 2) == 0) s = " \t";
    case ($urandom_range(0, 6))
      0, 1: s = {s, "int"};
      2:    s = {s, "char"};
      3:    s = {s, "long"};
      4:    s = {s, rand_id()};
      5:    s = {s, "inta"};
      default: ;
    endcase
    if ($urandom_range(0, 7) != 0) s = {s, " "};
    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) begin
      s = {s, rand_id()};
      case ($urandom_range(0, 9))
        0: s = {s, " = 42"};
        1: s = {s, "="};
        2: s = {s, " "};
        default: ;
      endcase
      if (i < n - 1) begin
        case ($urandom_range(0, 4))
          0: s = {s, ","};
          1: s = {s, " , "};
          2: s = {s, ",,"};
          3: s = {s, ", "};
          default: s = {s, " "};
        endcase
      end
    end
    if ($urandom_range(0, 9) == 0) s = {s, "#"};
    if ($urandom_range(0, 9) == 0) s = {s, ","};
    if ($urandom_range(0, 3) == 0) s = {s, " "};
    return {s, ";"};
  endfunction

  initial begin
    add("int a;",                      1, 0, 1, 0);
    add("  char x_1 , y,z ;",          1, 0, 3, 1);
    add("long int;",                   0, 1, 0, 0);
    add("int a,;",                     0, 1, 0, 0);
    add("inta b;",                     0, 1, 0, 0);
    add("int abcdefgh;",               1, 0, 1, 0);
    add("int abcdefghi;",              0, 1, 0, 0);
    add("\tlong q9,_r;",               1, 0, 2, 2);
    add("char 1a;",                    0, 1, 0, 0);
    add("int a b;",                    0, 1, 0, 0);
    add("long char_x;",                1, 0, 1, 2);
    add("int chars;",                  1, 0, 1, 0);
    add("int char;",                   0, 1, 0, 0);
    add("int;",                        0, 1, 0, 0);
    add("int a,b,c,d,e,f,g,h,i,j,k,l,m,n,o,p;", 1, 0, 15, 0);
`ifdef DECL_INIT_EN
    add("int a = 42, b;",              1, 0, 2, 0);
    add("int a = , b;",                0, 1, 0, 0);
    add("int a = 4 5;",                0, 1, 0, 0);
`else
    add("int a = 42, b;",              0, 1, 0, 0);
`endif

    do_reset();

    // Directed table at full rate, statements back to back.
    foreach (tbl[i]) begin
      send(tbl[i].txt, 0);
      if (tbl[i].e_out) begin
        chk("tbl_out", out, 1);
        chk("tbl_cnt", id_count, tbl[i].e_cnt);
        chk("tbl_ty", type_sel, tbl[i].e_ty);
      end else begin
        chk("tbl_out", out, 0);
      end
      chk("tbl_err", err, int'(tbl[i].e_err));
    end

    // Alternate idle cycles: pulse still lands right after the ';' beat.
    send("int a", 1);
    beat(8'h3b, 1'b1);
    chk("alt_out", out, 1);
    chk("alt_cnt", id_count, 1);
    beat(8'h00, 1'b0);
    chk("alt_out_clear", out, 0);
    send(";;", 0);
    chk("empty_err", err, 0);

    // Reset mid-statement discards it.
    send("int a", 0);
    do_reset();
    beat(8'h3b, 1'b1);
    chk("rst_discard_out", out, 0);
    chk("rst_discard_err", err, 0);

    // Random statements with random idle gaps.
    for (int i = 0; i < 400; i++) send(gen_stmt(), (i % 3 == 0) ? 2 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
